boreal_lms_error_gen: RTL and testbench

BOREAL_LMS_ERROR_GEN -- requirements
Module: boreal_lms_error_gen

---
 rtl/boreal_lms_error_gen.sv | 171 +++++++++++++++++
 tb/tb_boreal_lms_error_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_lms_error_gen.sv
// boreal_lms_error_gen: pairs targets with decoded predictions, emits clipped LMS error.
// Optional running-mean / divergence freeze enabled by macro BOREAL_ERR_AVG_EN.
module boreal_lms_error_gen (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               target_valid,
  input  logic signed [23:0] target_in,
  output logic               target_ready,
  input  logic               pred_valid,
  input  logic signed [23:0] pred_in,
  input  logic [22:0]        clip_thresh,
  input  logic [3:0]         decim,
  input  logic [22:0]        diverge_thresh,
  input  logic               freeze_clr,
  output logic               error_valid,
  output logic signed [23:0] error_signal,
  output logic               freeze_out,
  output logic [23:0]        err_mag_avg,
  output logic [7:0]         drop_count
);

  logic signed [23:0] fifo_mem [4];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         count;
  logic               push;
  logic               pred_fire;
  logic               pop;
  logic               drop;

  assign target_ready = (count != 3'd4);
  assign push         = target_valid && target_ready;
  assign pred_fire    = pred_valid && enable;
  assign pop          = pred_fire && (count != 3'd0);
  assign drop         = pred_fire && (count == 3'd0);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, data needs no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= target_in;
  end

  // saturating count of predictions that found no target
  always_ff @(posedge clk) begin
    if (rst)
      drop_count <= 8'd0;
    else if (drop && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end

  logic [3:0]         match_cnt;
  logic               match_hit;
  logic               s1_valid;
  logic signed [24:0] s1_diff;

  assign match_hit = (match_cnt == decim);

  // stage 1: decimation counter and wide difference
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= 4'd0;
      s1_valid  <= 1'b0;
      s1_diff   <= 25'sd0;
    end else begin
      s1_valid <= pop && match_hit;
      if (pop) begin
        s1_diff   <= {fifo_mem[rd_ptr][23], fifo_mem[rd_ptr]}
                   - {pred_in[23], pred_in};
        match_cnt <= match_hit ? 4'd0 : match_cnt + 4'd1;
      end
    end
  end

  logic signed [24:0] sat_val;
  logic signed [24:0] clip_pos;
  logic signed [24:0] clip_neg;
  logic signed [24:0] clip_val;
  logic signed [23:0] err_clip;
  logic               emit;

  // saturate to 24 bits, then clip symmetrically
  always_comb begin
    clip_pos = $signed({2'b00, clip_thresh});
    clip_neg = -clip_pos;
    if (s1_diff > 25'sh07FFFFF)
      sat_val = 25'sh07FFFFF;
    else if (s1_diff < 25'sh1800000)
      sat_val = 25'sh1800000;
    else
      sat_val = s1_diff;
    if (sat_val > clip_pos)
      clip_val = clip_pos;
    else if (sat_val < clip_neg)
      clip_val = clip_neg;
    else
      clip_val = sat_val;
    err_clip = clip_val[23:0];
  end

  assign emit = s1_valid && !freeze_out;

  // stage 2: output register, value held between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      error_valid  <= 1'b0;
      error_signal <= 24'sd0;
    end else begin
      error_valid <= emit;
      if (emit) error_signal <= err_clip;
    end
  end

`ifdef BOREAL_ERR_AVG_EN
  logic [23:0]        err_abs;
  logic signed [23:0] avg_diff;
  logic signed [23:0] avg_step;
  logic [23:0]        avg_next;
  logic               over;

  // magnitude with -2^23 folded to 2^23-1; 1/16 leaky mean
  always_comb begin
    if (err_clip == 24'sh800000)
      err_abs = 24'h7FFFFF;
    else if (err_clip[23])
      err_abs = $unsigned(-err_clip);
    else
      err_abs = $unsigned(err_clip);
    avg_diff = $signed(err_abs - err_mag_avg);
    avg_step = avg_diff >>> 4;
    avg_next = err_mag_avg + $unsigned(avg_step);
    over     = err_mag_avg > {1'b0, diverge_thresh};
  end

  // mean update per emitted error; set arms only while unfrozen
  always_ff @(posedge clk) begin
    if (rst) begin
      err_mag_avg <= 24'd0;
      freeze_out  <= 1'b0;
    end else begin
      if (emit) err_mag_avg <= avg_next;
      if (!freeze_out && over)
        freeze_out <= 1'b1;
      else if (freeze_clr)
        freeze_out <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{diverge_thresh, freeze_clr};
  assign err_mag_avg = 24'd0;
  assign freeze_out  = 1'b0;
`endif

endmodule

// File: tb/tb_boreal_lms_error_gen.sv
// tb_boreal_lms_error_gen: directed checks of pairing, clipping,
// decimation, drops, reset flush and the optional freeze path.
module tb_boreal_lms_error_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               target_valid;
  logic signed [23:0] target_in;
  logic               target_ready;
  logic               pred_valid;
  logic signed [23:0] pred_in;
  logic [22:0]        clip_thresh;
  logic [3:0]         decim;
  logic [22:0]        diverge_thresh;
  logic               freeze_clr;
  logic               error_valid;
  logic signed [23:0] error_signal;
  logic               freeze_out;
  logic [23:0]        err_mag_avg;
  logic [7:0]         drop_count;

  int total = 0;
  int bad   = 0;
  int q[$];

  boreal_lms_error_gen dut (
    .clk(clk), .rst(rst), .enable(enable),
    .target_valid(target_valid), .target_in(target_in),
    .target_ready(target_ready),
    .pred_valid(pred_valid), .pred_in(pred_in),
    .clip_thresh(clip_thresh), .decim(decim),
    .diverge_thresh(diverge_thresh), .freeze_clr(freeze_clr),
    .error_valid(error_valid), .error_signal(error_signal),
    .freeze_out(freeze_out), .err_mag_avg(err_mag_avg),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (error_valid === 1'b1) q.push_back(int'(error_signal));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic signed [23:0] v);
    target_valid = 1'b1;
    target_in    = v;
    tick;
    target_valid = 1'b0;
  endtask

  task automatic pred(input logic signed [23:0] v);
    pred_valid = 1'b1;
    pred_in    = v;
    tick;
    pred_valid = 1'b0;
  endtask

  task automatic settle;
    repeat (3) tick;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    target_valid = 1'b0; target_in = '0;
    pred_valid = 1'b0; pred_in = '0;
    clip_thresh = 23'h7FFFFF; decim = 4'd0;
    diverge_thresh = 23'd100; freeze_clr = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    chk("rst_ready", target_ready, 1);
    chk("rst_valid", error_valid, 0);
    chk("rst_signal", error_signal, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_freeze", freeze_out, 0);
    chk("rst_avg", err_mag_avg, 0);

    // basic pair, latency 2
    push(24'sd1000);
    pred_valid = 1'b1; pred_in = 24'sd400;
    tick;
    pred_valid = 1'b0;
    chk("lat_e0", error_valid, 0);
    tick;
    chk("lat_e1", error_valid, 1);
    chk("basic_600", error_signal, 600);
    tick;
    chk("one_cycle", error_valid, 0);
    chk("hold_600", error_signal, 600);

    // mid-pipeline reset discards sample
    q.delete();
    push(24'sd50);
    pred_valid = 1'b1; pred_in = 24'sd10;
    tick;
    pred_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    settle;
    chk("midrst_none", q.size(), 0);
    chk("midrst_sig", error_signal, 0);
    chk("midrst_ready", target_ready, 1);

    // saturation and clipping
    q.delete();
    push(24'sh7FFFFF);
    pred(24'sh800000);
    settle;
    chk("sat_pos", q[0], 8388607);
    q.delete();
    push(24'sh800000);
    pred(24'sh7FFFFF);
    settle;
    chk("sat_neg_clip", q[0], -8388607);
    clip_thresh = 23'd5000;
    q.delete();
    push(24'sh7FFFFF);
    pred(24'sh800000);
    settle;
    chk("clip_5000", q[0], 5000);
    q.delete();
    push(-24'sd9000);
    pred(24'sd0);
    settle;
    chk("clip_m5000", q[0], -5000);
    clip_thresh = 23'h7FFFFF;

    // fill FIFO, fifth rejected
    for (int i = 1; i <= 3; i++) push(24'(i * 10));
    chk("ready_at3", target_ready, 1);
    push(24'sd40);
    chk("full_at4", target_ready, 0);
    push(24'sd50);
    chk("full_at5", target_ready, 0);
    q.delete();
    pred_valid = 1'b1; pred_in = 24'sd1;
    repeat (4) tick;
    pred_valid = 1'b0;
    settle;
    chk("fifo_n", q.size(), 4);
    chk("fifo_0", q[0], 9);
    chk("fifo_1", q[1], 19);
    chk("fifo_2", q[2], 29);
    chk("fifo_3", q[3], 39);
    chk("fifo_nodrop", drop_count, 0);
    pred(24'sd0);
    chk("fifth_lost", drop_count, 1);

    // enable gating, then push+pop same cycle
    q.delete();
    push(24'sd7);
    enable = 1'b0;
    pred(24'sd2);
    settle;
    chk("en_low_none", q.size(), 0);
    chk("en_low_drop", drop_count, 1);
    enable = 1'b1;
    target_valid = 1'b1; target_in = 24'sd8;
    pred_valid = 1'b1; pred_in = 24'sd2;
    tick;
    target_valid = 1'b0; pred_valid = 1'b0;
    pred(24'sd3);
    settle;
    chk("pp_n", q.size(), 2);
    chk("pp_0", q[0], 5);
    chk("pp_1", q[1], 5);
    pred(24'sd0);
    chk("pp_empty", drop_count, 2);

    // drop counter saturation; same-cycle push does not rescue
    q.delete();
    pred_valid = 1'b1; pred_in = 24'sd0;
    repeat (300) tick;
    pred_valid = 1'b0;
    settle;
    chk("drop_none", q.size(), 0);
    chk("drop_255", drop_count, 255);

    // decimation by 3
    decim = 4'd2;
    q.delete();
    for (int i = 1; i <= 6; i++) begin
      push(24'(i * 100));
      pred(24'sd0);
    end
    settle;
    chk("dec_n", q.size(), 2);
    chk("dec_0", q[0], 300);
    chk("dec_1", q[1], 600);
    decim = 4'd0;

`ifdef BOREAL_ERR_AVG_EN
    for (int i = 0; i < 8; i++) begin
      push(24'sd10000);
      pred(24'sd0);
    end
    settle;
    chk("frz_set", freeze_out, 1);
    chk("avg_high", err_mag_avg > 24'd100, 1);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      push(24'sd10000);
      pred(24'sd0);
    end
    settle;
    chk("frz_suppress", q.size(), 0);
    freeze_clr = 1'b1;
    tick;
    freeze_clr = 1'b0;
    chk("frz_clr", freeze_out, 0);
    tick;
    chk("frz_reset", freeze_out, 1);
`else
    freeze_clr = 1'b1;
    diverge_thresh = 23'd1;
    tick;
    freeze_clr = 1'b0;
    tick;
    chk("noavg_avg", err_mag_avg, 0);
    chk("noavg_frz", freeze_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
